spram256x8_ctrl: RTL and testbench

//  Request/response front-end that sits directly upstream of the SPRAM256X8

---
 rtl/spram256x8_ctrl_if.sv | 22 ++
 rtl/spram256x8_ctrl.sv | 126 ++++++++++++
 tb/tb_spram256x8_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spram256x8_ctrl_if.sv
// Request/response bundle between a requester and the SPRAM256X8 front-end.
// Latency: none, wires only.
// Backpressure: req_ready throttles requests; the rsp side has no backpressure.
interface spram256x8_ctrl_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/spram256x8_ctrl.sv
// Sole driver of the SPRAM256X8 pins: holds the RAM idle through the power-up window, then issues one op per clock.
// Latency: read data returns as a one-cycle rsp_valid pulse 2 clocks after the accept edge; writes produce no response.
// Backpressure: req_ready is low until RUN, then always high; rsp has no backpressure. SPRAM_CLEAR_EN adds a zero-fill pass before RUN.
module spram256x8_ctrl #(
   parameter int INIT_CYCLES = 200,
   parameter int CNT_W       = $clog2(INIT_CYCLES + 1)
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   spram256x8_ctrl_if.slave     bus,
   output logic                 init_done,
   output logic [7:0]           ram_D,
   output logic [7:0]           ram_ADR,
   output logic                 ram_ENB,
   output logic                 ram_WEB,
   output logic                 ram_OEB,
   input  logic [7:0]           ram_Q
);

   typedef enum logic [1:0] {ST_INIT, ST_CLEAR, ST_RUN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       rd_pend;
   logic             accept;
   logic             rd_acc;
`ifdef SPRAM_CLEAR_EN
   logic [7:0]       clr_addr, clr_addr_nxt;
`endif

   assign bus.req_ready = (state == ST_RUN);
   assign init_done     = (state == ST_RUN);
   assign accept        = bus.req_valid & bus.req_ready;
   assign rd_acc        = accept & ~bus.req_we;

   // State, quiet-window counter and clear address registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= ST_INIT;
         cnt      <= '0;
`ifdef SPRAM_CLEAR_EN
         clr_addr <= '0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
`ifdef SPRAM_CLEAR_EN
         clr_addr <= clr_addr_nxt;
`endif
      end
   end

   // Next-state: count out the quiet window, optionally zero-fill, then stay in RUN.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
`ifdef SPRAM_CLEAR_EN
      clr_addr_nxt = clr_addr;
`endif
      case (state)
         ST_INIT: begin
            if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
`ifdef SPRAM_CLEAR_EN
               state_nxt = ST_CLEAR;
`else
               state_nxt = ST_RUN;
`endif
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_CLEAR: begin
`ifdef SPRAM_CLEAR_EN
            clr_addr_nxt = clr_addr + 8'd1;
            if (clr_addr == 8'hFF) state_nxt = ST_RUN;
`else
            state_nxt = ST_INIT;
`endif
         end
         default: ;
      endcase
   end

   // RAM pin registers: ENB/WEB pulse low for one cycle per op, ADR/D hold otherwise.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         ram_ENB <= 1'b1;
         ram_WEB <= 1'b1;
         ram_OEB <= 1'b1;
         ram_ADR <= '0;
         ram_D   <= '0;
      end else begin
         ram_ENB <= 1'b1;
         ram_WEB <= 1'b1;
         ram_OEB <= (state != ST_RUN);
`ifdef SPRAM_CLEAR_EN
         if (state == ST_CLEAR) begin
            ram_ENB <= 1'b0;
            ram_WEB <= 1'b0;
            ram_ADR <= clr_addr;
            ram_D   <= 8'h00;
         end else
`endif
         if (accept) begin
            ram_ENB <= 1'b0;
            ram_WEB <= ~bus.req_we;
            ram_ADR <= bus.req_addr;
            ram_D   <= bus.req_wdata;
         end
      end
   end

   // Read tracking: stage 0 = pins driven, stage 1 = Q valid; capture Q on the next edge.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rd_pend       <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
      end else begin
         rd_pend       <= {rd_pend[0], rd_acc};
         bus.rsp_valid <= rd_pend[1];
         if (rd_pend[1]) bus.rsp_rdata <= ram_Q;
      end
   end

endmodule

// File: tb/tb_spram256x8_ctrl.sv
// Directed bench for spram256x8_ctrl with a behavioural SPRAM256X8 model.
// Latency: checks the 2-clock read response and the power-up readiness delay.
// Backpressure: none exercised; every rsp_valid pulse is logged and compared.
module tb_spram256x8_ctrl;
   localparam int INIT_CYCLES = 200;
`ifdef SPRAM_CLEAR_EN
   localparam int READY_LAT = INIT_CYCLES + 256;
`else
   localparam int READY_LAT = INIT_CYCLES;
`endif

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       init_done;
   logic [7:0] ram_D, ram_ADR, ram_Q;
   logic       ram_ENB, ram_WEB, ram_OEB;

   spram256x8_ctrl_if bus ();

   spram256x8_ctrl #(.INIT_CYCLES(INIT_CYCLES)) dut (
      .CLK(CLK), .RST_N(RST_N), .bus(bus), .init_done(init_done),
      .ram_D(ram_D), .ram_ADR(ram_ADR), .ram_ENB(ram_ENB),
      .ram_WEB(ram_WEB), .ram_OEB(ram_OEB), .ram_Q(ram_Q)
   );

   always #5 CLK = ~CLK;

   // SPRAM model: op executes on the edge where ENB is low; Q gated by OEB.
   logic [7:0] mem [256];
   logic [7:0] q_reg = 8'h00;
   int         rel_cnt = 0;
   int         viol = 0;
   initial for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
   assign ram_Q = ram_OEB ? 8'h00 : q_reg;

   always @(posedge CLK) begin
      if (!ram_ENB) begin
         if (!ram_WEB) mem[ram_ADR] <= ram_D;
         else          q_reg <= mem[ram_ADR];
      end
      if (!RST_N) rel_cnt <= 0;
      else begin
         if (!ram_ENB && rel_cnt < INIT_CYCLES) viol <= viol + 1;
         rel_cnt <= rel_cnt + 1;
      end
   end

   // Cycle stamp and response log.
   int         cyc = 0;
   int         rsp_cyc [$];
   logic [7:0] rsp_dat [$];
   always @(posedge CLK) cyc <= cyc + 1;
   always @(posedge CLK) begin
      #1;
      if (bus.rsp_valid) begin
         rsp_cyc.push_back(cyc);
         rsp_dat.push_back(bus.rsp_rdata);
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Present a request for one edge; leaves req_valid high for chaining.
   task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] data, output int t);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = data;
      @(posedge CLK);
      #1;
      t = cyc;
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (n < 2000) begin
         @(posedge CLK);
         #1;
         n++;
         if (bus.req_ready) break;
      end
   endtask

   task automatic expect_rsp(input string tag, input int t, input logic [7:0] d);
      if (rsp_cyc.size() == 0) begin
         chk({tag, "_present"}, 0, 1);
      end else begin
         chk({tag, "_lat"}, rsp_cyc.pop_front() - t, 2);
         chk({tag, "_dat"}, rsp_dat.pop_front(), d);
      end
   endtask

   initial begin
      int n, t, t0;
      RST_N = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      tick(2);

      // Reset values
      chk("rst_enb",   ram_ENB, 1);
      chk("rst_web",   ram_WEB, 1);
      chk("rst_oeb",   ram_OEB, 1);
      chk("rst_adr",   ram_ADR, 0);
      chk("rst_d",     ram_D, 0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_rspv",  bus.rsp_valid, 0);
      chk("rst_rdata", bus.rsp_rdata, 0);
      chk("rst_done",  init_done, 0);

      RST_N = 1'b1;
      wait_ready(n);
      chk("ready_lat", n, READY_LAT);
      chk("init_done", init_done, 1);
      tick(1);

      // Write then read
      issue(1'b1, 8'h3C, 8'hA5, t);
      idle();
      issue(1'b0, 8'h3C, 8'h00, t);
      idle();
      tick(4);
      chk("s2_count", rsp_cyc.size(), 1);
      expect_rsp("s2", t, 8'hA5);
      chk("s2_hold", bus.rsp_rdata, 8'hA5);

      // Three writes then back-to-back reads, consecutive ordered pulses
      issue(1'b1, 8'h00, 8'h11, t);
      issue(1'b1, 8'hFF, 8'h22, t);
      issue(1'b1, 8'h80, 8'h33, t);
      issue(1'b0, 8'h00, 8'h00, t0);
      issue(1'b0, 8'hFF, 8'h00, t);
      issue(1'b0, 8'h80, 8'h00, t);
      idle();
      tick(5);
      chk("s3_count", rsp_cyc.size(), 3);
      expect_rsp("s3_r0", t0,     8'h11);
      expect_rsp("s3_r1", t0 + 1, 8'h22);
      expect_rsp("s3_r2", t0 + 2, 8'h33);

      // Write immediately followed by a read of the same address
      issue(1'b1, 8'h10, 8'h5A, t);
      issue(1'b0, 8'h10, 8'h00, t);
      idle();
      tick(4);
      chk("s4_count", rsp_cyc.size(), 1);
      expect_rsp("s4", t, 8'h5A);

      // Reset while a read is in flight
      issue(1'b0, 8'h3C, 8'h00, t);
      idle();
      RST_N = 1'b0;
      tick(1);
      chk("s5_enb", ram_ENB, 1);
      chk("s5_ready", bus.req_ready, 0);
      tick(1);
      RST_N = 1'b1;
      tick(4);
      chk("s5_norsp", rsp_cyc.size(), 0);
      chk("s5_rdata", bus.rsp_rdata, 0);
      wait_ready(n);
      chk("s5_ready_lat", n + 4, READY_LAT);
      tick(1);

`ifdef SPRAM_CLEAR_EN
      // Never-written location reads back zero after the clear pass
      issue(1'b0, 8'h7F, 8'h00, t);
      idle();
      tick(4);
      chk("s6_count", rsp_cyc.size(), 1);
      expect_rsp("s6", t, 8'h00);
`endif

      chk("quiet_window", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
